alu_op_dispatcher: RTL and testbench



---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_lat_timer.sv | 45 ++++
 rtl/alu_op_dispatcher.sv | 155 +++++++++++++++
 tb/tb_alu_op_dispatcher.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, default bus widths, dispatcher
// state encoding and the opcode legality check. The ALU imports this too.
package alu_pkg;

    localparam int ALU_DATA_W = 24;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD   = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_SUB   = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_PASSA = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_PASSB = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_INCA  = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_DECA  = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_LSH1  = 4'd7;
    localparam logic [ALU_OP_W-1:0] OP_LSH2  = 4'd8;
    localparam logic [ALU_OP_W-1:0] OP_LSH8  = 4'd9;
    localparam logic [ALU_OP_W-1:0] OP_RSH4  = 4'd10;
    localparam logic [ALU_OP_W-1:0] OP_RESET = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } disp_state_e;

    // Legal opcodes form the contiguous range ADD..RESET.
    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_RESET);
    endfunction

endpackage

// File: rtl/alu_lat_timer.sv
// Loadable down-counter; done_o is high during the cycle the loaded count
// reaches zero, after which the timer goes idle until reloaded.
module alu_lat_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // Next count: load wins, otherwise count down while active.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load_i) begin
            cnt_d    = load_val_i;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/alu_op_dispatcher.sv
// ALU operation dispatcher: takes one opcode per request, strobes the ALU,
// waits out its fixed latency, and returns the captured result.
// Optional build macro DISPATCH_PERF_CNT_EN adds op_count/err_count outputs.
//
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | one-cycle enable strobe to the ALU, timer loaded
//   WAIT  | counting down the ALU latency, capture at zero
//   RESP  | response presented until accepted
module alu_op_dispatcher
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int OP_W    = ALU_OP_W,
    parameter int ALU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    output logic [OP_W-1:0]   alu_operation,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_c_bus,
    input  logic              alu_z_flag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
`ifdef DISPATCH_PERF_CNT_EN
    output logic [15:0]       op_count,
    output logic [7:0]        err_count,
`endif
    output logic              busy
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    disp_state_e       state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;
    logic              tmr_load;
    logic              tmr_done;
    logic              req_legal;

    assign req_legal = is_legal_op(req_op);

    alu_lat_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (CNT_W'(ALU_LAT - 1)),
        .done_o     (tmr_done)
    );

    // Next-state and response capture logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        zero_d   = zero_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        op_d    = req_op;
                        state_d = ST_ISSUE;
                    end else begin
                        // Illegal opcode: answer immediately, ALU untouched.
                        data_d  = '0;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                tmr_load = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (tmr_done) begin
                    data_d  = alu_c_bus;
                    // Only SUB drives a meaningful zero flag.
                    zero_d  = (op_q == OP_SUB) ? alu_z_flag : (alu_c_bus == '0);
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign alu_enable    = (state_q == ST_ISSUE);
    assign rsp_valid     = (state_q == ST_RESP);
    assign alu_operation = op_q;
    assign rsp_data      = data_q;
    assign rsp_zero      = zero_q;
    assign rsp_err       = err_q;

`ifdef DISPATCH_PERF_CNT_EN
    logic [15:0] op_cnt_q;
    logic [7:0]  err_cnt_q;

    // Free-running wrap-around counters of issued and rejected requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (state_q == ST_ISSUE) begin
                op_cnt_q <= op_cnt_q + 16'd1;
            end
            if ((state_q == ST_IDLE) && req_valid && !req_legal) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign op_count  = op_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed bench for alu_op_dispatcher with a latency-accurate ALU model.
module tb_alu_op_dispatcher;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [3:0]  alu_operation;
    logic        alu_enable;
    logic [23:0] alu_c_bus;
    logic        alu_z_flag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;
`ifdef DISPATCH_PERF_CNT_EN
    logic [15:0] op_count;
    logic [7:0]  err_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_op_dispatcher #(.DATA_W(24), .OP_W(4), .ALU_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .alu_operation (alu_operation),
        .alu_enable    (alu_enable),
        .alu_c_bus     (alu_c_bus),
        .alu_z_flag    (alu_z_flag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_zero      (rsp_zero),
        .rsp_err       (rsp_err),
`ifdef DISPATCH_PERF_CNT_EN
        .op_count      (op_count),
        .err_count     (err_count),
`endif
        .busy          (busy)
    );

    // ALU model: result valid only in the cycle LAT cycles after the strobe,
    // garbage otherwise, so a mistimed capture shows up.
    int          cd;
    logic [23:0] mdl_data;
    logic        mdl_z;
    always @(posedge clk or posedge rst) begin
        if (rst)             cd <= 0;
        else if (alu_enable) cd <= LAT;
        else if (cd != 0)    cd <= cd - 1;
    end
    assign alu_c_bus  = (cd == 1) ? mdl_data : 24'h5A5A5A;
    assign alu_z_flag = (cd == 1) ? mdl_z : ~mdl_z;

    // Log every enable strobe with its cycle number and opcode.
    int         cyc = 0;
    int         en_cyc[$];
    logic [3:0] en_op[$];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (alu_enable) begin
            en_cyc.push_back(cyc);
            en_op.push_back(alu_operation);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present a request, complete the handshake, and count cycles until rsp_valid.
    task automatic do_op(input logic [3:0] op, input logic [23:0] d, input logic z,
                         output int lat);
        int n;
        mdl_data = d;
        mdl_z    = z;
        @(negedge clk);
        req_op    = op;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [23:0] cbus;
        logic        zf;
        int          exp_lat;
        logic [23:0] exp_data;
        logic        exp_zero;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        int base;
        int n;
        int seen;

        vecs[0] = '{4'd1,  24'h000123, 1'b0, LAT+2, 24'h000123, 1'b0, 1'b0}; // ADD
        vecs[1] = '{4'd2,  24'h000000, 1'b1, LAT+2, 24'h000000, 1'b1, 1'b0}; // SUB flag=1
        vecs[2] = '{4'd2,  24'h000000, 1'b0, LAT+2, 24'h000000, 1'b0, 1'b0}; // SUB flag=0
        vecs[3] = '{4'd3,  24'h000000, 1'b0, LAT+2, 24'h000000, 1'b1, 1'b0}; // PASSA zero data
        vecs[4] = '{4'd9,  24'hABCDEF, 1'b1, LAT+2, 24'hABCDEF, 1'b0, 1'b0}; // LSH8 flag ignored
        vecs[5] = '{4'hF,  24'h111111, 1'b1, 1,     24'h000000, 1'b0, 1'b1}; // illegal
        vecs[6] = '{4'h0,  24'h222222, 1'b0, 1,     24'h000000, 1'b0, 1'b1}; // illegal
        vecs[7] = '{4'hC,  24'h333333, 1'b0, 1,     24'h000000, 1'b0, 1'b1}; // illegal
        vecs[8] = '{4'd11, 24'h000001, 1'b0, LAT+2, 24'h000001, 1'b0, 1'b0}; // RESET

        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; rsp_ready = 1'b0;
        mdl_data = 24'd0; mdl_z = 1'b0;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_enable", 32'(alu_enable), 32'd0);
        chk("rst_alu_operation", 32'(alu_operation), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            base = en_cyc.size();
            do_op(vecs[i].op, vecs[i].cbus, vecs[i].zf, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_rsp_zero", i), 32'(rsp_zero), 32'(vecs[i].exp_zero));
            chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_enable_count", i), 32'(en_cyc.size() - base),
                vecs[i].exp_err ? 32'd0 : 32'd1);
            if (!vecs[i].exp_err && en_cyc.size() > base)
                chk($sformatf("v%0d_alu_operation", i), 32'(en_op[base]), 32'(vecs[i].op));
            ack();
            chk($sformatf("v%0d_rsp_valid_drop", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d_hold_in_idle", i), 32'(rsp_data), 32'(vecs[i].exp_data));
        end

        // Reset in the middle of WAIT abandons the SUB.
        mdl_data = 24'h000000; mdl_z = 1'b1;
        @(negedge clk);
        req_op = 4'd2; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midwait_busy", 32'(busy), 32'd1);
        chk("midwait_operation", 32'(alu_operation), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_alu_operation", 32'(alu_operation), 32'd0);
        chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
        chk("midrst_alu_enable", 32'(alu_enable), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("midrst_no_response", 32'(seen), 32'd0);
        do_op(4'd1, 24'h000042, 1'b0, lat);
        chk("postrst_latency", 32'(lat), 32'(LAT + 2));
        chk("postrst_rsp_data", 32'(rsp_data), 32'h000042);
        ack();

        // Backpressure: hold rsp_ready low, offer a competing request.
        do_op(4'd4, 24'h00BEEF, 1'b0, lat);
        chk("bp_latency", 32'(lat), 32'(LAT + 2));
        base = en_cyc.size();
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin
                req_op = 4'd1; req_valid = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rsp_data", k), 32'(rsp_data), 32'h00BEEF);
            chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        ack();
        repeat (8) @(negedge clk);
        chk("bp_no_extra_issue", 32'(en_cyc.size() - base), 32'd0);
        chk("bp_idle_after", 32'(busy), 32'd0);

        // Back-to-back INCA then RSH4 with rsp_ready tied high.
        rsp_ready = 1'b1;
        mdl_data = 24'h000777; mdl_z = 1'b0;
        base = en_cyc.size();
        @(negedge clk);
        req_op = 4'd5; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_op = 4'd10;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("b2b_second_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (en_cyc.size() < base + 2 && n < 50) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        rsp_ready = 1'b0;
        chk("b2b_enable_count", 32'(en_cyc.size() - base), 32'd2);
        if (en_cyc.size() >= base + 2) begin
            chk("b2b_spacing", 32'(en_cyc[base+1] - en_cyc[base]), 32'(LAT + 3));
            chk("b2b_op_first", 32'(en_op[base]), 32'd5);
            chk("b2b_op_second", 32'(en_op[base+1]), 32'd10);
        end
        chk("b2b_final_data", 32'(rsp_data), 32'h000777);
`ifdef DISPATCH_PERF_CNT_EN
        // Since the mid-WAIT reset: ADD, PASSB, INCA, RSH4 issued, no errors.
        chk("perf_op_count", 32'(op_count), 32'd4);
        chk("perf_err_count", 32'(err_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
